// File: rtl/rv64g_l1_refill_arbiter.sv
// rv64g_l1_refill_arbiter: round-robin sharing of the single L1 refill port, one refill in flight.
// Optional same-line completion merging enabled by defining RFARB_COALESCE_EN.
module rv64g_l1_refill_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int OWNER_W    = 2,
  parameter int LINE_OFF_W = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*64-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]    req_done_o,
  output logic                  refill_req_o,
  output logic [63:0]           refill_addr_o,
  input  logic                  refill_done_i,
  output logic                  busy_o,
  output logic [OWNER_W-1:0]    owner_o
);
  localparam int LW = 64 - LINE_OFF_W;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  state_t state_q, state_d;
  logic [OWNER_W-1:0] rr_q, owner_q, grant_idx;
  logic [OWNER_W:0]   idx;
  logic [63:0]        addr_q, grant_addr;
  logic               grant_any;
  logic [NUM_REQ-1:0] owner_hot;
  // Descending scan so the lowest offset from rr_q is the last (winning) assignment.
  always_comb begin
    grant_any = |req_valid_i;
    grant_idx = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_q} + (OWNER_W+1)'(i);
      idx = (idx >= (OWNER_W+1)'(NUM_REQ)) ? idx - (OWNER_W+1)'(NUM_REQ) : idx;
      if (req_valid_i[idx[OWNER_W-1:0]]) grant_idx = idx[OWNER_W-1:0];
    end
  end
  assign grant_addr = req_addr_i[grant_idx*64 +: 64];
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = grant_any ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = refill_done_i ? S_DONE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && grant_any) begin
        owner_q <= grant_idx;
        addr_q  <= {grant_addr[63:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
      end
      if (state_q == S_DONE)
        rr_q <= (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    end
  end
  assign busy_o        = state_q != S_IDLE;
  assign refill_req_o  = state_q == S_ISSUE;
  assign refill_addr_o = (state_q == S_ISSUE || state_q == S_WAIT) ? addr_q : '0;
  assign owner_o       = busy_o ? owner_q : '0;
  assign owner_hot     = NUM_REQ'(1) << owner_q;
`ifdef RFARB_COALESCE_EN
  logic [NUM_REQ-1:0] merge_q, match;
  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_REQ; k++)
      match[k] = (state_q == S_WAIT || state_q == S_DONE) && req_valid_i[k] &&
                 OWNER_W'(k) != owner_q && req_addr_i[k*64+LINE_OFF_W +: LW] == addr_q[63:LINE_OFF_W];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == S_DONE) merge_q <= '0;
    else if (state_q == S_WAIT) merge_q <= merge_q | match;
  end
  // A same-line source seen in the DONE cycle itself is merged into this pulse too.
  assign req_done_o = (state_q == S_DONE) ? owner_hot | merge_q | match : '0;
`else
  assign req_done_o = (state_q == S_DONE) ? owner_hot : '0;
`endif
endmodule

// File: tb/tb_rv64g_l1_refill_arbiter.sv
// tb_rv64g_l1_refill_arbiter: directed scoreboard bench for the L1 refill arbiter.
module tb_rv64g_l1_refill_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [255:0] req_addr = '0;
  logic         refill_done = 1'b0;
  logic [3:0]   req_done;
  logic         refill_req;
  logic [63:0]  refill_addr;
  logic         busy;
  logic [1:0]   owner;
  typedef struct packed {logic [1:0] owner; logic [63:0] addr;} exp_t;
  exp_t sb[$];
  int total = 0, passed = 0, failed = 0;

  rv64g_l1_refill_arbiter dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_done_o(req_done), .refill_req_o(refill_req), .refill_addr_o(refill_addr),
    .refill_done_i(refill_done), .busy_o(busy), .owner_o(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(int k, logic [63:0] a);
    req_addr[k*64 +: 64] = a;
  endtask

  task automatic expect_refill(logic [1:0] o, logic [63:0] a);
    exp_t e;
    e.owner = o;
    e.addr  = a;
    sb.push_back(e);
  endtask

  task automatic wait_refill(string tag);
    exp_t e;
    int n = 0;
    while (refill_req !== 1'b1 && n < 12) begin
      tick;
      n++;
    end
    chk({tag, "_issued"}, {63'd0, refill_req}, 64'd1);
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    else begin
      e = sb.pop_front();
      chk({tag, "_addr"}, refill_addr, e.addr);
      chk({tag, "_owner"}, {62'd0, owner}, {62'd0, e.owner});
    end
  endtask

  task automatic complete(string tag, logic [3:0] mask);
    refill_done = 1'b1;
    tick;
    refill_done = 1'b0;
    chk(tag, {60'd0, req_done}, {60'd0, mask});
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_req"}, {63'd0, refill_req}, 64'd0);
    chk({tag, "_addr"}, refill_addr, 64'd0);
    chk({tag, "_owner"}, {62'd0, owner}, 64'd0);
    chk({tag, "_done"}, {60'd0, req_done}, 64'd0);
  endtask

  initial begin
    tick;
    tick;
    rst = 1'b0;
    chk_idle("reset");
    // round robin from rr=0 with every source continuously requesting
    for (int k = 0; k < 4; k++) set_addr(k, 64'h2000_0000 + 64'(k) * 64'h100 + 64'h3F);
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      expect_refill(2'(g % 4), 64'h2000_0000 + 64'(g % 4) * 64'h100);
      wait_refill("rr");
      tick;
      complete("rr_done", 4'b0001 << (g % 4));
    end
    req_valid = '0;
    tick;
    // single source, exact latency, early done ignored, valid dropped after grant
    set_addr(2, 64'h8000_1234);
    req_valid = 4'b0100;
    expect_refill(2'd2, 64'h8000_1200);
    tick;
    chk("single_latency", {63'd0, refill_req}, 64'd1);
    wait_refill("single");
    refill_done = 1'b1;
    set_addr(2, 64'hDEAD_BEEF_0000_0000);
    req_valid = '0;
    tick;
    refill_done = 1'b0;
    tick;
    tick;
    chk("early_done_busy", {63'd0, busy}, 64'd1);
    chk("early_done_nodone", {60'd0, req_done}, 64'd0);
    chk("wait_noreq", {63'd0, refill_req}, 64'd0);
    chk("wait_addr_held", refill_addr, 64'h8000_1200);
    complete("single_done", 4'b0100);
    chk("done_owner", {62'd0, owner}, 64'd2);
    chk("done_addr_zero", refill_addr, 64'd0);
    tick;
    chk("single_back_idle", {63'd0, busy}, 64'd0);
    // wrap: rr=3, sources 3 and 0 -> 3 then 0; source 1 drops before grant
    set_addr(3, 64'h3000_0000);
    set_addr(0, 64'h3000_1000);
    req_valid = 4'b1001;
    expect_refill(2'd3, 64'h3000_0000);
    expect_refill(2'd0, 64'h3000_1000);
    wait_refill("wrap3");
    tick;
    complete("wrap3_done", 4'b1000);
    req_valid = 4'b0001;
    wait_refill("wrap0");
    tick;
    set_addr(1, 64'h5000_0000);
    req_valid = 4'b0011;
    tick;
    req_valid = 4'b0001;
    complete("wrap0_done", 4'b0001);
    req_valid = '0;
    tick;
    tick;
    tick;
    chk("dropped_req_busy", {63'd0, busy}, 64'd0);
    chk("dropped_req_noreq", {63'd0, refill_req}, 64'd0);
    // two sources on the same line, second raised during WAIT
    set_addr(0, 64'h1000_0040);
    set_addr(1, 64'h1000_0040);
    req_valid = 4'b0001;
    expect_refill(2'd0, 64'h1000_0040);
    wait_refill("co0");
    tick;
    req_valid = 4'b0011;
    tick;
`ifdef RFARB_COALESCE_EN
    complete("co_done_merged", 4'b0011);
    req_valid = '0;
    tick;
    tick;
    tick;
    chk("co_single_refill", {63'd0, busy}, 64'd0);
`else
    complete("co_done0", 4'b0001);
    req_valid = 4'b0010;
    expect_refill(2'd1, 64'h1000_0040);
    wait_refill("co1");
    tick;
    complete("co_done1", 4'b0010);
    req_valid = '0;
    tick;
`endif
    // reset in WAIT, later done ignored, rr restarts at 0
    set_addr(3, 64'h7000_0080);
    req_valid = 4'b1000;
    expect_refill(2'd3, 64'h7000_0080);
    wait_refill("rst_pre");
    req_valid = '0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_idle("rst_mid");
    refill_done = 1'b1;
    tick;
    refill_done = 1'b0;
    chk("rst_late_done", {60'd0, req_done}, 64'd0);
    chk("rst_late_busy", {63'd0, busy}, 64'd0);
    set_addr(1, 64'h6000_0000);
    set_addr(3, 64'h6000_1000);
    req_valid = 4'b1010;
    expect_refill(2'd1, 64'h6000_0000);
    wait_refill("post_rst_rr");
    tick;
    complete("post_rst_done", 4'b0010);
    req_valid = '0;
    tick;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
